// File: rtl/cls_frame_scheduler.sv
// Arbitrates two frame requesters onto the PmodCLS SPI serializer and sequences SS setup, start, completion, watchdog and gap.
// Optional build macro CLS_SCHED_RR_EN selects round-robin arbitration instead of fixed priority (requester 0 first).
module cls_frame_scheduler #(
    parameter int          DATASIZE        = 152,
    parameter int          SS_SETUP_CYCLES = 100,
    parameter int          GAP_CYCLES      = 1000,
    parameter int unsigned TIMEOUT_CYCLES  = 24'd2000000,
    parameter int          CNT_W           = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [DATASIZE-1:0] data0,
    input  logic [DATASIZE-1:0] data1,
    output logic [1:0]          done,
    output logic                err,
    output logic                busy,
    output logic [DATASIZE-1:0] send_data,
    output logic                begin_transmission,
    output logic                slave_select,
    input  logic                end_transmission
);

    typedef enum logic [2:0] {IDLE, SETUP, START, BUSY, GAP} state_e;

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  grant_q, grant_d;
    logic [DATASIZE-1:0]   send_data_q, send_data_d;
    logic                  begin_q, begin_d;
    logic                  ss_q, ss_d;
    logic [1:0]            done_q, done_d;
    logic                  err_q, err_d;
    logic                  win;
`ifdef CLS_SCHED_RR_EN
    logic                  last_q, last_d;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        send_data_d = send_data_q;
        begin_d     = 1'b0;
        ss_d        = ss_q;
        done_d      = 2'b00;
        err_d       = 1'b0;
`ifdef CLS_SCHED_RR_EN
        last_d      = last_q;
        win         = (req == 2'b11) ? ~last_q : req[1];
`else
        win         = ~req[0];
`endif

        case (state_q)
            IDLE: begin
                ss_d = 1'b1;
                if (req != 2'b00) begin
                    grant_d     = win;
                    send_data_d = win ? data1 : data0;
                    ss_d        = 1'b0;
                    cnt_d       = '0;
                    state_d     = SETUP;
`ifdef CLS_SCHED_RR_EN
                    last_d      = win;
`endif
                end
            end
            SETUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETUP_LAST) begin
                    begin_d = 1'b1;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion in the same cycle as the watchdog limit counts as a good frame.
                if (end_transmission) begin
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == GAP_LAST) begin
                    ss_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            send_data_q <= '0;
            begin_q     <= 1'b0;
            ss_q        <= 1'b1;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            send_data_q <= send_data_d;
            begin_q     <= begin_d;
            ss_q        <= ss_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef CLS_SCHED_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    assign busy               = (state_q != IDLE);
    assign send_data          = send_data_q;
    assign begin_transmission = begin_q;
    assign slave_select       = ss_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule

// File: tb/tb_cls_frame_scheduler.sv
// Directed self-checking bench for cls_frame_scheduler; define CLS_SCHED_RR_EN to check the round-robin build.
module tb_cls_frame_scheduler;

    localparam int DW      = 152;
    localparam int SS      = 100;
    localparam int GAPC    = 1000;
    localparam int TMO     = 5000;
    localparam int SER_DLY = 40;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req;
    logic [DW-1:0]  data0, data1;
    logic [1:0]     done;
    logic           err, busy;
    logic [DW-1:0]  send_data;
    logic           begin_transmission, slave_select, end_transmission;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Results of the most recent do_frame call
    int            r_lat, r_t_busy, r_gap;
    logic [DW-1:0] r_sd;
    logic [1:0]    r_done, r_done_w;
    logic          r_err, r_begin_w, r_busy_end, r_ss_fell;
    bit            r_timeout, r_extra_done;

    cls_frame_scheduler #(
        .DATASIZE(DW), .SS_SETUP_CYCLES(SS), .GAP_CYCLES(GAPC),
        .TIMEOUT_CYCLES(TMO), .CNT_W(24)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .done(done), .err(err), .busy(busy), .send_data(send_data),
        .begin_transmission(begin_transmission), .slave_select(slave_select),
        .end_transmission(end_transmission)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL global_watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Runs one frame from IDLE; send_end selects whether the serializer model answers.
    task automatic do_frame(input logic [1:0] rv, input bit send_end, input bit hold,
                            input bit drop_setup, input bit spur);
        int  t0, tb, td;
        bit  got;
        r_timeout = 0; r_extra_done = 0;
        req = rv; t0 = cyc;
        got = 0;
        for (int k = 0; k < SS + 50; k++) begin
            @(negedge clk);
            if (k == 0) r_ss_fell = (slave_select === 1'b0) && (busy === 1'b1);
            if (drop_setup && k == 1) begin data0 = ~data0; req = 2'b00; end
            end_transmission = spur && (k == 10);
            if (done !== 2'b00) r_extra_done = 1;
            if (begin_transmission === 1'b1) begin got = 1; tb = cyc; r_sd = send_data; break; end
        end
        end_transmission = 1'b0;
        if (!got) begin r_timeout = 1; return; end
        r_lat = tb - t0;
        @(negedge clk);
        r_begin_w = begin_transmission;
        got = 0;
        for (int k = 0; k < TMO + 50; k++) begin
            if (done !== 2'b00) begin got = 1; break; end
            end_transmission = send_end && (k == SER_DLY);
            @(negedge clk);
            end_transmission = 1'b0;
        end
        if (!got) begin r_timeout = 1; return; end
        td = cyc; r_done = done; r_err = err; r_t_busy = td - tb;
        if (!hold) req = 2'b00;
        @(negedge clk);
        r_done_w = done;
        got = 0;
        for (int k = 0; k < GAPC + 50; k++) begin
            if (slave_select === 1'b1) begin got = 1; break; end
            if (done !== 2'b00) r_extra_done = 1;
            end_transmission = spur && (k == 5);
            @(negedge clk);
            end_transmission = 1'b0;
        end
        if (!got) begin r_timeout = 1; return; end
        r_gap = cyc - td; r_busy_end = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0; end_transmission = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (slave_select !== 1'b1) begin errors++; $display("FAIL reset_ss got=%b exp=1", slave_select); end
        checks++; if (begin_transmission !== 1'b0) begin errors++; $display("FAIL reset_begin got=%b exp=0", begin_transmission); end
        checks++; if (done !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%b/%b exp=00/0", done, err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (send_data !== '0) begin errors++; $display("FAIL reset_send_data got=%h exp=0", send_data); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] a5;
        a5 = {19{8'hA5}};
        data1 = a5; data0 = {19{8'h11}};
        do_frame(2'b10, 1, 0, 0, 0);
        checks++; if (r_timeout) begin errors++; $display("FAIL single_bound got=expired exp=complete"); end
        checks++; if (r_ss_fell !== 1'b1) begin errors++; $display("FAIL single_ss_fall got=%b exp=1", r_ss_fell); end
        checks++; if (r_lat != SS + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", r_lat, SS + 1); end
        checks++; if (r_begin_w !== 1'b0) begin errors++; $display("FAIL single_begin_width got=%b exp=0", r_begin_w); end
        checks++; if (r_sd !== a5) begin errors++; $display("FAIL single_send_data got=%h exp=%h", r_sd, a5); end
        checks++; if (r_done !== 2'b10 || r_err !== 1'b0) begin errors++; $display("FAIL single_done got=%b/%b exp=10/0", r_done, r_err); end
        checks++; if (r_done_w !== 2'b00) begin errors++; $display("FAIL single_done_width got=%b exp=00", r_done_w); end
        checks++; if (r_gap != GAPC) begin errors++; $display("FAIL single_gap got=%0d exp=%0d", r_gap, GAPC); end
        checks++; if (r_busy_end !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", r_busy_end); end
    endtask

    task automatic test_priority();
        logic [1:0]    exp_g [3];
        logic [DW-1:0] exp_sd;
`ifdef CLS_SCHED_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`endif
        data0 = {19{8'h3C}}; data1 = {19{8'hA5}};
        for (int i = 0; i < 3; i++) begin
            do_frame(2'b11, 1, (i < 2), 0, 0);
            exp_sd = (exp_g[i] == 2'b10) ? data1 : data0;
            checks++; if (r_timeout || r_done !== exp_g[i]) begin errors++; $display("FAIL prio_grant%0d got=%b exp=%b", i, r_done, exp_g[i]); end
            checks++; if (r_sd !== exp_sd) begin errors++; $display("FAIL prio_data%0d got=%h exp=%h", i, r_sd, exp_sd); end
            checks++; if (r_lat != SS + 1) begin errors++; $display("FAIL prio_latency%0d got=%0d exp=%0d", i, r_lat, SS + 1); end
        end
    endtask

    task automatic test_timeout();
        do_frame(2'b10, 0, 0, 0, 0);
        checks++; if (r_timeout || r_done !== 2'b10 || r_err !== 1'b1) begin errors++; $display("FAIL timeout_done_err got=%b/%b exp=10/1", r_done, r_err); end
        checks++; if (r_t_busy != TMO + 1) begin errors++; $display("FAIL timeout_delay got=%0d exp=%0d", r_t_busy, TMO + 1); end
        checks++; if (r_gap != GAPC) begin errors++; $display("FAIL timeout_gap got=%0d exp=%0d", r_gap, GAPC); end
        do_frame(2'b01, 1, 0, 0, 0);
        checks++; if (r_timeout || r_done !== 2'b01 || r_err !== 1'b0) begin errors++; $display("FAIL after_timeout_frame got=%b/%b exp=01/0", r_done, r_err); end
    endtask

    task automatic test_data_hold();
        logic [DW-1:0] orig;
        orig = {19{8'h5A}};
        data0 = orig;
        do_frame(2'b01, 1, 0, 1, 0);
        checks++; if (r_sd !== orig) begin errors++; $display("FAIL hold_send_data got=%h exp=%h", r_sd, orig); end
        checks++; if (r_timeout || r_done !== 2'b01) begin errors++; $display("FAIL hold_done got=%b exp=01", r_done); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit got, saw_done;
        got = 0; saw_done = 0;
        req = 2'b01;
        for (int k = 0; k < SS + 50; k++) begin
            @(negedge clk);
            if (begin_transmission === 1'b1) begin got = 1; break; end
        end
        checks++; if (!got) begin errors++; $display("FAIL rstmid_begin got=none exp=pulse"); end
        repeat (20) @(negedge clk);
        #2 rst = 1'b1; req = 2'b00;
        #1;
        checks++; if (slave_select !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got=ss%b/busy%b exp=ss1/busy0", slave_select, busy); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done !== 2'b00) saw_done = 1;
        end
        rst = 1'b0;
        checks++; if (saw_done) begin errors++; $display("FAIL rstmid_no_done got=pulse exp=none"); end
        @(negedge clk);
        do_frame(2'b01, 1, 0, 0, 0);
        checks++; if (r_timeout || r_done !== 2'b01 || r_lat != SS + 1) begin errors++; $display("FAIL rstmid_recover got=%b lat=%0d exp=01 lat=%0d", r_done, r_lat, SS + 1); end
    endtask

    task automatic test_spurious();
        do_frame(2'b10, 1, 0, 0, 1);
        checks++; if (r_lat != SS + 1) begin errors++; $display("FAIL spur_latency got=%0d exp=%0d", r_lat, SS + 1); end
        checks++; if (r_extra_done) begin errors++; $display("FAIL spur_extra_done got=pulse exp=none"); end
        checks++; if (r_timeout || r_done !== 2'b10) begin errors++; $display("FAIL spur_done got=%b exp=10", r_done); end
        checks++; if (r_gap != GAPC) begin errors++; $display("FAIL spur_gap got=%0d exp=%0d", r_gap, GAPC); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_priority();
        test_timeout();
        test_data_hold();
        test_reset_mid();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
